serv_decode_queue: RTL
======================

# serv_decode_queue

Parametrised predecode queue between the instruction bus and serv state/control logic. Each accepted instruction word is predecoded at write time into a compact control word. Instruction and control word are then stored together in a DEPTH-entry circular buffer. The queue lets fetch run ahead of the bit-serial core, adds illegal-instruction detection, and supports a single-cycle flush for taken branches and traps.

## Interface
Parameters:
- DEPTH, 2: queue entries. Must be a power of two, minimum 2.
- MDU, 0: 1 means funct7[0]=1 OP instructions are valid M-extension ops. 0 means they decode as illegal.
- CW, 12: control-word width. Fixed by the package; not overridden.

Ports:
- clk  in  1: clock. Single clock domain.
- i_rst  in  1: reset. Synchronous, active-high.
- i_wb_rdt  in  30: instruction bits [31:2] from ibus.
- i_wb_en  in  1: push request. The word is valid this cycle.
- o_ready  out  1: queue can accept a push this cycle.
- i_flush  in  1: discard all stored entries.
- o_valid  out  1: head entry present.
- i_ack  in  1: pop the head entry. Honoured only when o_valid.
- o_insn  out  30: head instruction [31:2].
- o_funct3  out  3: head funct3.
- o_rd_op, o_two_stage_op, o_shift_op, o_branch_op, o_dbus_en, o_mdu_op, o_csr_op, o_e_op, o_mret, o_illegal  out  1 each: head control bits.
- o_count  out  $clog2(DEPTH+1): number of stored entries.
- o_ovf  out  1: one-cycle pulse when a push is attempted while o_ready=0.

## Operation
- Predecode is combinational on i_wb_rdt. The result is written with the instruction on push.
- Predecode equations:
  - rd_op = op[2] | (op[4]&op[0]) | (!op[3]&!op[0]).
  - two_stage_op = !op[2] | (f3[0]&!f3[1]&!op[0]&!op[4]) | (f3[1]&!f3[2]&!op[0]&!op[4]) | mdu_op.
  - shift_op = op[2] & !f3[1] & !mdu_op.
  - branch_op = op[4].
  - dbus_en = !op[2] & !op[4].
  - mdu_op = MDU & op==01100 & b25.
  - csr_op = op[4] & op[2] & |f3.
  - e_op = op[4] & op[2] & !b21 & !(b22&b28) & f3==0.
  - mret = op[4] & op[2] & b21 & f3==0.
- illegal = 1 when any of the following holds:
  - op[6:2] is not in {00000, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011, 11100}.
  - op==01100, b25=1 and MDU=0.
  - op==11001 and f3!=0.
- Illegal entries are still stored and presented. o_illegal is the only distinguishing signal.
- Push is accepted iff i_wb_en & o_ready. o_ready = (count != DEPTH); there is no pop-to-push bypass when full.
- Pop is accepted iff i_ack & o_valid. i_ack when empty is ignored.
- When push and pop are both accepted in the same cycle, the count is unchanged and both pointers advance.
- Flush sets rd_ptr = wr_ptr and count = 0. A push in the same cycle as a flush is accepted (post-flush fetch) and the result is count=1. A pop in the same cycle as a flush is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Entries are selected by rd_ptr, not shifted.
- All head outputs except o_insn are forced to 0 when o_valid=0. o_insn is don't-care when o_valid=0.
- Reset values:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - o_valid = 0, o_ready = 1, o_ovf = 0.
  - All control outputs 0.
  - Storage contents are not reset.

## Timing
- Latency: a word pushed at edge N is visible at the head after edge N, i.e. o_valid=1 in cycle N+1 when the queue was empty. There is no same-cycle passthrough.
- o_ready, o_valid and o_count are registered-state functions. They have no combinational path from i_wb_en, i_ack or i_flush.
- o_ovf is registered and asserts in the cycle after the rejected push.
- Reset asserted mid-stream clears state at the next edge. A push during reset is dropped.
- Maximum throughput is one push and one pop per cycle.

## Structure
- Package serv_decode_pkg holds:
  - Opcode constants: OP_LOAD, OP_MISC, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM.
  - Control-word bit indices and CW.
- Sub-module serv_predecode: purely combinational, i_insn[31:2] -> o_ctrl[CW-1:0], parameter MDU.
- Top level serv_decode_queue: pointers, count, storage array of DEPTH x (30+CW), ovf register and output gating.

## Test plan
- Reset, then push 0x00A00093 (addi x1,x0,10) -> next cycle o_valid=1, o_rd_op=1, o_two_stage_op=0, o_illegal=0, o_count=1.
- DEPTH=2: push 3 words back-to-back with no ack -> o_ready=0 after 2 pushes, third push dropped, o_ovf pulses once, o_count=2, head is still the first word.
- Simultaneous push and ack with count=1 for 8 cycles -> o_count stays 1, pops return words in order, pointers wrap without loss.
- Count=2, then i_flush together with a push of 0x0000006F (jal) -> next cycle o_count=1, head is jal, o_branch_op=1.
- MDU=0: push 0x02208033 (mul) -> o_illegal=1, o_mdu_op=0. With MDU=1 the same word gives o_illegal=0, o_mdu_op=1, o_two_stage_op=1.
- Push 0x30200073 (mret) then 0x00100073 (ebreak) -> o_mret=1, o_e_op=0; then o_e_op=1, o_mret=0. i_ack on an empty queue leaves o_count=0.

Source files
------------

// File: rtl/serv_decode_pkg.sv
// Shared constants for the serv predecode queue: opcode field values and
// control-word bit positions.
package serv_decode_pkg;

  localparam int CW = 12;

  // Major opcode values, instruction bits [6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // Control-word bit indices; bits above C_ILLEGAL are spare and stored as 0
  localparam int C_RD      = 0;
  localparam int C_TWO     = 1;
  localparam int C_SHIFT   = 2;
  localparam int C_BRANCH  = 3;
  localparam int C_DBUS    = 4;
  localparam int C_MDU     = 5;
  localparam int C_CSR     = 6;
  localparam int C_E       = 7;
  localparam int C_MRET    = 8;
  localparam int C_ILLEGAL = 9;

  function automatic logic legal_opcode(input logic [4:0] op);
    logic legal;
    case (op)
      OP_LOAD, OP_MISC, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/serv_predecode.sv
// Combinational predecode of one instruction word into the compact control
// word stored alongside it in the queue.
module serv_predecode
  import serv_decode_pkg::*;
#(
  parameter bit MDU = 1'b0
) (
  input  logic [31:2]   i_insn,
  output logic [CW-1:0] o_ctrl
);

  logic [4:0] op;
  logic [2:0] f3;
  logic       mdu_op;

  assign op     = i_insn[6:2];
  assign f3     = i_insn[14:12];
  assign mdu_op = MDU && (op == OP_OP) && i_insn[25];

  // NOTE: every bit gets a default first so no path leaves o_ctrl unassigned (no latch).
  always_comb begin
    o_ctrl            = '0;
    o_ctrl[C_RD]      = op[2] | (op[4] & op[0]) | (!op[3] & !op[0]);
    o_ctrl[C_TWO]     = !op[2] | (f3[0] & !f3[1] & !op[0] & !op[4])
                      | (f3[1] & !f3[2] & !op[0] & !op[4]) | mdu_op;
    o_ctrl[C_SHIFT]   = op[2] & !f3[1] & !mdu_op;
    o_ctrl[C_BRANCH]  = op[4];
    o_ctrl[C_DBUS]    = !op[2] & !op[4];
    o_ctrl[C_MDU]     = mdu_op;
    o_ctrl[C_CSR]     = op[4] & op[2] & (|f3);
    o_ctrl[C_E]       = op[4] & op[2] & !i_insn[21] & !(i_insn[22] & i_insn[28]) & (f3 == 3'b000);
    o_ctrl[C_MRET]    = op[4] & op[2] & i_insn[21] & (f3 == 3'b000);
    o_ctrl[C_ILLEGAL] = !legal_opcode(op)
                      | ((op == OP_OP) & i_insn[25] & !MDU)
                      | ((op == OP_JALR) & (|f3));
  end

  logic unused_insn;
  assign unused_insn = ^{i_insn[31:29], i_insn[27:26], i_insn[24:23],
                         i_insn[20:15], i_insn[11:7]};

endmodule

// File: rtl/serv_decode_queue.sv
// Circular queue of predecoded instructions between the ibus and the serv
// core, with single-cycle flush and registered overflow pulse.
module serv_decode_queue
  import serv_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter bit MDU   = 1'b0
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [29:0]                i_wb_rdt,
  input  logic                       i_wb_en,
  output logic                       o_ready,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ack,
  output logic [29:0]                o_insn,
  output logic [2:0]                 o_funct3,
  output logic                       o_rd_op,
  output logic                       o_two_stage_op,
  output logic                       o_shift_op,
  output logic                       o_branch_op,
  output logic                       o_dbus_en,
  output logic                       o_mdu_op,
  output logic                       o_csr_op,
  output logic                       o_e_op,
  output logic                       o_mret,
  output logic                       o_illegal,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  localparam int EW = 30 + CW;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] count;
  logic          ovf;
  logic [EW-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ctrl, head_ctrl;
  logic [29:0]   head_insn;
  logic          valid, ready, push, pop;

  serv_predecode #(.MDU(MDU)) u_predecode (
    .i_insn (i_wb_rdt),
    .o_ctrl (wr_ctrl)
  );

  assign valid = (count != '0);
  assign ready = (count != NW'(DEPTH));
  // A flush frees every slot, so the post-flush fetch is taken even when full.
  assign push  = i_wb_en && (ready || i_flush);
  assign pop   = i_ack && valid && !i_flush;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= i_wb_en && !push;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (i_flush) begin
        rd_ptr <= wr_ptr;
        count  <= push ? NW'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + NW'(1);
        else if (pop && !push) count <= count - NW'(1);
      end
    end
  end

  // NOTE: storage is deliberately left unreset; count/valid gate everything read from it.
  always_ff @(posedge clk) begin
    if (push && !i_rst) mem[wr_ptr] <= {wr_ctrl, i_wb_rdt};
  end

  assign {head_ctrl, head_insn} = mem[rd_ptr];

  assign o_ready        = ready;
  assign o_valid        = valid;
  assign o_count        = count;
  assign o_ovf          = ovf;
  assign o_insn         = head_insn;
  assign o_funct3       = valid ? head_insn[12:10] : 3'b000;
  assign o_rd_op        = valid & head_ctrl[C_RD];
  assign o_two_stage_op = valid & head_ctrl[C_TWO];
  assign o_shift_op     = valid & head_ctrl[C_SHIFT];
  assign o_branch_op    = valid & head_ctrl[C_BRANCH];
  assign o_dbus_en      = valid & head_ctrl[C_DBUS];
  assign o_mdu_op       = valid & head_ctrl[C_MDU];
  assign o_csr_op       = valid & head_ctrl[C_CSR];
  assign o_e_op         = valid & head_ctrl[C_E];
  assign o_mret         = valid & head_ctrl[C_MRET];
  assign o_illegal      = valid & head_ctrl[C_ILLEGAL];

  logic unused_ctrl;
  assign unused_ctrl = ^head_ctrl[CW-1:C_ILLEGAL+1];

endmodule
